// File: rtl/snn_cfg_pkg.sv
// Shared definitions for the SNN configuration loader: region codes, FSM states and network geometry.
package snn_cfg_pkg;

    localparam logic [1:0] REGION_W = 2'd0;
    localparam logic [1:0] REGION_D = 2'd1;
    localparam logic [1:0] REGION_P = 2'd2;

    localparam int unsigned N_SYN1     = 192;
    localparam int unsigned N_SYN2     = 16;
    localparam int unsigned DELAY_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DROP
    } cfg_state_t;

    // Byte size of a region for a given weight precision; 0 marks the illegal region.
    function automatic int unsigned region_bytes(input logic [1:0] region, input int unsigned nbits);
        int unsigned size;
        size = 0;
        case (region)
            REGION_W: size = (N_SYN1 + N_SYN2) * nbits / 8;
            REGION_D: size = (N_SYN1 + N_SYN2) * DELAY_BITS / 8;
            REGION_P: size = (3 * nbits + 7) / 8;
            default:  size = 0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/snn_cfg_bytebank.sv
// Byte-addressable register file with flat output; only the low VALID_BITS bits are stored, the rest read as 0.
module snn_cfg_bytebank #(
    parameter int unsigned NBYTES     = 1,
    parameter int unsigned VALID_BITS = 8 * NBYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [7:0]            waddr,
    input  logic [7:0]            wdata,
    output logic [VALID_BITS-1:0] q
);

    // Bit-wise write so bits beyond VALID_BITS are never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int unsigned b = 0; b < VALID_BITS; b++) begin
                if (waddr == 8'(b / 8)) begin
                    q[b] <= wdata[b % 8];
                end
            end
        end
    end

endmodule

// File: rtl/snn_config_loader.sv
// Byte-serial framed configuration loader feeding the weight, delay and scalar-parameter buses of the SNN top.
module snn_config_loader
    import snn_cfg_pkg::*;
#(
    parameter int unsigned Nbits = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic [208*Nbits-1:0]   weights,
    output logic [831:0]           delays,
    output logic [Nbits-1:0]       threshold,
    output logic [Nbits-1:0]       decay,
    output logic [Nbits-1:0]       refractory_period,
    output logic                   busy,
    output logic                   cfg_done,
    output logic                   cfg_error
);

    localparam int unsigned W_BYTES = region_bytes(REGION_W, Nbits);
    localparam int unsigned D_BYTES = region_bytes(REGION_D, Nbits);
    localparam int unsigned P_BYTES = region_bytes(REGION_P, Nbits);

    cfg_state_t state, state_nxt;
    logic [1:0] region, region_nxt;
    logic [7:0] ptr, ptr_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       done_nxt;
    logic       error_nxt;
    logic       we_w, we_d, we_p;
    logic [8:0] end_idx;
    logic [8:0] region_size;
    logic [3*Nbits-1:0] p_q;

    assign in_ready = 1'b1;
    assign busy     = (state != IDLE);

    // Range check at 9 bits so ADDR+LEN cannot wrap back into range.
    assign end_idx     = {1'b0, ptr} + {1'b0, in_data};
    assign region_size = 9'(region_bytes(region, Nbits));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            region    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            region    <= region_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            cfg_done  <= done_nxt;
            cfg_error <= error_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        region_nxt = region;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        error_nxt  = cfg_error;
        we_w       = 1'b0;
        we_d       = 1'b0;
        we_p       = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    region_nxt = in_data[1:0];
                    state_nxt  = S_ADDR;
                end
                S_ADDR: begin
                    ptr_nxt   = in_data;
                    state_nxt = S_LEN;
                end
                S_LEN: begin
                    cnt_nxt = in_data;
                    if (region_size == '0 || end_idx >= region_size) begin
                        error_nxt = 1'b1;
                        state_nxt = S_DROP;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    we_w    = (region == REGION_W);
                    we_d    = (region == REGION_D);
                    we_p    = (region == REGION_P);
                    ptr_nxt = ptr + 8'd1;
                    if (cnt == '0) begin
                        done_nxt  = 1'b1;
                        error_nxt = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                S_DROP: begin
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    snn_cfg_bytebank #(
        .NBYTES     (W_BYTES),
        .VALID_BITS (8 * W_BYTES)
    ) u_weights (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (we_w),
        .waddr (ptr),
        .wdata (in_data),
        .q     (weights)
    );

    snn_cfg_bytebank #(
        .NBYTES     (D_BYTES),
        .VALID_BITS (8 * D_BYTES)
    ) u_delays (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (we_d),
        .waddr (ptr),
        .wdata (in_data),
        .q     (delays)
    );

    snn_cfg_bytebank #(
        .NBYTES     (P_BYTES),
        .VALID_BITS (3 * Nbits)
    ) u_params (
        .clk   (clk),
        .rst_n (reset_n),
        .we    (we_p),
        .waddr (ptr),
        .wdata (in_data),
        .q     (p_q)
    );

    assign threshold         = p_q[Nbits-1:0];
    assign decay             = p_q[2*Nbits-1:Nbits];
    assign refractory_period = p_q[3*Nbits-1:2*Nbits];

endmodule

// File: tb/tb_snn_config_loader.sv
// Frame-level bench for snn_config_loader: table of frames, reference image model and expected-result queue.
module tb_snn_config_loader;

    localparam int NB = 4;
    localparam int WB = 26 * NB;
    localparam int DB = 104;
    localparam int PB = (3 * NB + 7) / 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [208*NB-1:0] weights;
    logic [831:0]      delays;
    logic [NB-1:0]     threshold;
    logic [NB-1:0]     decay;
    logic [NB-1:0]     refractory_period;
    logic              busy;
    logic              cfg_done;
    logic              cfg_error;

    snn_config_loader #(.Nbits(NB)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .weights           (weights),
        .delays            (delays),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .busy              (busy),
        .cfg_done          (cfg_done),
        .cfg_error         (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] addr;
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        bit         stall;
        bit         exp_err;
    } vec_t;

    typedef struct {
        logic [831:0]    w;
        logic [831:0]    d;
        logic [3*NB-1:0] p;
        logic            err;
        logic            done;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];

    logic [8*WB-1:0] m_w;
    logic [8*DB-1:0] m_d;
    logic [8*PB-1:0] m_p;

    int n_cmp = 0;
    int n_bad = 0;
    bit busy_ok;
    bit done_early;

    task automatic chk(input string name, input logic [831:0] act, input logic [831:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_weights"}, weights, '0);
        chk({tag, "_delays"}, delays, '0);
        chk({tag, "_params"}, {refractory_period, decay, threshold}, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, cfg_done, 1'b0);
        chk({tag, "_error"}, cfg_error, 1'b0);
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        logic [7:0] b;
        int idx;
        // Expected image computed up front and queued
        for (int k = 0; k <= int'(v.len); k++) begin
            b   = 8'(int'(v.base) + k * int'(v.step));
            idx = int'(v.addr) + k;
            if (!v.exp_err) begin
                case (v.hdr[1:0])
                    2'd0: m_w[8*idx +: 8] = b;
                    2'd1: m_d[8*idx +: 8] = b;
                    2'd2: m_p[8*idx +: 8] = b;
                    default: ;
                endcase
            end
        end
        m_p    = m_p & ((1 << (3 * NB)) - 1);
        e.w    = m_w;
        e.d    = m_d;
        e.p    = m_p[3*NB-1:0];
        e.err  = v.exp_err;
        e.done = !v.exp_err;
        sb.push_back(e);

        busy_ok    = 1'b1;
        done_early = 1'b0;
        send_byte(v.hdr, 1'b0);
        if (busy !== 1'b1) busy_ok = 1'b0;
        send_byte(v.addr, 1'b0);
        if (busy !== 1'b1) busy_ok = 1'b0;
        send_byte(v.len, 1'b0);
        for (int k = 0; k <= int'(v.len); k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cfg_done !== 1'b0) done_early = 1'b1;
            send_byte(8'(int'(v.base) + k * int'(v.step)), v.stall);
        end

        e = sb.pop_front();
        chk("frame_busy_end", busy, 1'b0);
        chk("frame_done", cfg_done, e.done);
        chk("frame_error", cfg_error, e.err);
        chk("frame_weights", weights, e.w);
        chk("frame_delays", delays, e.d);
        chk("frame_params", {refractory_period, decay, threshold}, e.p);
        chk("frame_busy_held", busy_ok, 1'b1);
        chk("frame_no_early_done", done_early, 1'b0);
        @(posedge clk);
        #1;
        chk("frame_done_pulse", cfg_done, 1'b0);
        chk("frame_error_sticky", cfg_error, e.err);
    endtask

    initial begin
        tbl[0]  = '{8'hA0, 8'h00, 8'h67, 8'h00, 8'h01, 1'b0, 1'b0};
        tbl[1]  = '{8'h02, 8'h00, 8'h01, 8'h5A, 8'hA9, 1'b0, 1'b0};
        tbl[2]  = '{8'h01, 8'h64, 8'h04, 8'h11, 8'h01, 1'b0, 1'b1};
        tbl[3]  = '{8'h01, 8'h10, 8'h03, 8'hC0, 8'h03, 1'b0, 1'b0};
        tbl[4]  = '{8'h03, 8'h00, 8'h00, 8'h77, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h02, 8'h01, 8'h01, 8'h12, 8'h01, 1'b0, 1'b1};
        tbl[7]  = '{8'h00, 8'h67, 8'h00, 8'h99, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{8'h00, 8'hFF, 8'h01, 8'hAB, 8'h01, 1'b0, 1'b1};
        tbl[9]  = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b1};
        tbl[10] = '{8'hFE, 8'h00, 8'h00, 8'hC3, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'h00, 8'h00, 8'h67, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[12] = '{8'h01, 8'h67, 8'h00, 8'h8F, 8'h00, 1'b1, 1'b0};

        m_w = '0;
        m_d = '0;
        m_p = '0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            send_frame(tbl[i]);
            if (i == 0) begin
                chk("w_byte0", weights[7:0], 8'h00);
                chk("w_byte103", weights[831:824], 8'h67);
            end
            if (i == 1) begin
                chk("threshold", threshold, 4'hA);
                chk("decay", decay, 4'h5);
                chk("refractory", refractory_period, 4'h3);
            end
            if (i == 5) chk("refractory_ff", refractory_period, 4'hF);
            if (i == 11) chk("w_byte103_restored", weights[831:824], 8'h67);
        end

        // Set the sticky error, then reset in the middle of a payload
        send_frame('{8'h03, 8'h05, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1});
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h0F, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(8'hEE, 1'b0);
        chk("mid_frame_busy", busy, 1'b1);
        reset_n = 1'b0;
        #2;
        check_idle_outputs("mid_reset");
        m_w = '0;
        m_d = '0;
        m_p = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame('{8'h00, 8'h02, 8'h03, 8'h30, 8'h05, 1'b0, 1'b0});
        chk("post_reset_byte2", weights[23:16], 8'h30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
